store_queue_mw: RTL and testbench
=================================

STORE_QUEUE_MW -- requirements
Module: store_queue_mw

Interface
REQ-001 Parameter SQ_DEPTH, default 3, log2 of entry count; entries NUM_SQ = 2**SQ_DEPTH.
REQ-002 Parameter ROB_DEPTH, default 3, width of ROB index.
REQ-003 Parameter CDB_SIZE, default 4, number of CDB snoop ports.
REQ-004 Parameter ISSUE_WIDTH, default 2, allocation lanes per cycle (1..NUM_SQ).
REQ-005 clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-006 move_flush  in  1  squash all entries, same effect as rst.
REQ-007 issue_valid[ISSUE_WIDTH]  in  1  allocate request per lane.
REQ-008 issue_funct3 / issue_imm / issue_target_rob [ISSUE_WIDTH]  in  3/32/ROB_DEPTH  store op, offset, own ROB tag.
REQ-009 issue_rs{1,2}_ready, issue_rs{1,2}_v, issue_rs{1,2}_rob [ISSUE_WIDTH]  in  1/32/ROB_DEPTH  pre-resolved operand state.
REQ-010 sq_alloc_ready  out  1  free slots >= ISSUE_WIDTH.
REQ-011 sq_free_count  out  SQ_DEPTH+1  free entries; sq_alloc_ptr  out  SQ_DEPTH  next slot for lane 0.
REQ-012 cdb_valid/cdb_rob/cdb_rd_v [CDB_SIZE]  in  1/ROB_DEPTH/32  result broadcast.
REQ-013 rob_head  in  ROB_DEPTH  oldest uncommitted ROB tag; store_buffer_full  in  1  downstream back-pressure.
REQ-014 sq_valid, sq_addr_ready, sq_data_ready [NUM_SQ]  out  1  per-entry state for load disambiguation.
REQ-015 sq_addr, sq_wdata [NUM_SQ] out 32; sq_wmask [NUM_SQ] out 4  per-entry store image.
REQ-016 cdb_sq_valid out 1, cdb_sq_rob out ROB_DEPTH, cdb_sq_addr out 32, cdb_sq_wmask out 4, cdb_sq_wdata out 32  retiring store.

Function
REQ-017 Circular FIFO; alloc_ptr (tail) and ret_ptr (head) wrap modulo NUM_SQ; occupancy counter SQ_DEPTH+1 bits.
REQ-018 Lanes compacted: the k-th asserted issue_valid lane writes entry alloc_ptr+k; alloc_ptr advances by number of asserted lanes.
REQ-019 Allocation taken only when sq_alloc_ready=1; issue_valid while not ready ignored, no state change.
REQ-020 Operand capture at allocation: issue ready -> value; else same-cycle CDB match on rob tag -> CDB value, ready=1 (bypass); else wait.
REQ-021 Waiting operand of valid entry captures lowest-index matching CDB port; only unready operands update.
REQ-022 sq_addr_ready = valid & rs1 ready; sq_data_ready = valid & rs1 ready & rs2 ready.
REQ-023 addr = rs1_v + imm (mod 2**32); sb: wmask 0001<<addr[1:0], byte at lane addr[1:0]; sh: 0011<<addr[1:0], half at addr[1]; sw: 1111, full word; other funct3: wmask 0, wdata 0.
REQ-024 Retire (combinational): cdb_sq_valid = entry[ret_ptr] valid & data_ready & target_rob==rob_head & !store_buffer_full.
REQ-025 On retire: cdb_sq_* carry entry[ret_ptr] image; entry cleared; ret_ptr+1; at most one retire per cycle.
REQ-026 cdb_sq_rob/addr/wmask/wdata = 0 when cdb_sq_valid=0.
REQ-027 Simultaneous allocation and retire: occupancy += lanes - 1; a slot freed this cycle not reusable until next cycle.
REQ-028 sq_free_count = NUM_SQ - occupancy; full at 0, empty at NUM_SQ; no overflow/underflow.

Reset
REQ-029 On rst or move_flush: pointers 0, occupancy 0, all entries invalid with fields 0; flush overrides same-cycle issue and retire.
REQ-030 After reset: sq_free_count=NUM_SQ, sq_alloc_ready=1, sq_alloc_ptr=0, all per-entry outputs 0 except wmask per REQ-023 on zero fields, cdb_sq_valid=0.

Structure
REQ-031 funct3 encodings (sb_mem, sh_mem, sw_mem) come from rv32i_types; no new package types.
REQ-032 Store-image formation (addr, funct3, rs2 -> wmask, wdata) is one sub-module, store_align, instanced per entry and for retire port.

Verification
REQ-033 Two lanes issue sw (rs1=0x100, imm 4, rs2=0xDEADBEEF) and sb (rs1=0x203, imm 0, rs2=0xAB), all ready -> entries 0,1; wmask 1111/1000, wdata 0xDEADBEEF/0xAB000000; free=6.
REQ-034 rs2 pending on tag 5; CDB port 2 broadcasts tag 5 value 0x1234 same cycle as allocation -> data_ready=1 next cycle, wdata 0x1234.
REQ-035 Fill 8 entries -> alloc_ready=0, further issue ignored; retire with rob_head match and 2-lane issue same cycle -> only retire; 8th-to-9th wrap lands at entry 0 after retire.
REQ-036 Head ready but store_buffer_full=1 or rob_head mismatch -> cdb_sq_valid=0 hold; release -> single-cycle retire with correct image.
REQ-037 move_flush asserted with issue and retire active -> next cycle free=8, all valid 0, cdb_sq_valid=0.
REQ-038 sh at addr 0x202 (rs2=0xBEEF) -> wmask 1100, wdata 0xBEEF0000; funct3=3 -> wmask 0000.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package : rv32i_types
// Purpose : Shared RV32I encodings used by the memory pipeline.
//           Only the store funct3 encodings are consumed by the store queue.
// Revision: 1.0  initial release
// ============================================================================
package rv32i_types;

  // Store width encodings carried in funct3 of S-type instructions
  typedef enum logic [2:0] {
    sb_mem = 3'b000,
    sh_mem = 3'b001,
    sw_mem = 3'b010
  } store_funct3_t;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module  : store_align
// Purpose : Forms the byte-lane image of a store from its address offset,
//           funct3 and rs2 value. Bytes and halves are placed in the lane
//           selected by the address; unknown funct3 produces an empty image.
// Ports   : addr_lo  in  2   low address bits (byte offset in word)
//           funct3   in  3   store width encoding
//           rs2      in  32  store source value
//           wmask    out 4   byte-enable mask
//           wdata    out 32  lane-aligned store data
// Revision: 1.0  initial release
// ============================================================================
module store_align
  import rv32i_types::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  always_comb begin
    wmask = 4'b0000;
    wdata = 32'h0000_0000;
    case (funct3)
      sb_mem: begin
        wmask = 4'b0001 << addr_lo;
        wdata = {24'h00_0000, rs2[7:0]} << {addr_lo, 3'b000};
      end
      sh_mem: begin
        // A misaligned half (offset 3) keeps only the lane that fits the word
        wmask = 4'b0011 << addr_lo;
        wdata = {16'h0000, rs2[15:0]} << {addr_lo[1], 4'b0000};
      end
      sw_mem: begin
        wmask = 4'b1111;
        wdata = rs2;
      end
      default: begin
        wmask = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

endmodule : store_align
`default_nettype wire

// File: rtl/store_queue_mw.sv
`default_nettype none
// ============================================================================
// Module  : store_queue_mw
// Purpose : Multi-issue circular store queue. Allocates up to ISSUE_WIDTH
//           stores per cycle (lanes compacted onto consecutive slots),
//           snoops the CDB for pending operands, exposes per-entry state for
//           load disambiguation and retires at most one store per cycle once
//           it reaches the ROB head.
// Ports   : clk, rst             clock, synchronous active-high reset
//           move_flush           squash all entries
//           issue_*[ISSUE_WIDTH] allocation lanes with pre-resolved operands
//           sq_alloc_ready       at least ISSUE_WIDTH free slots
//           sq_free_count        free entries
//           sq_alloc_ptr         slot lane 0 would be written to
//           cdb_*[CDB_SIZE]      result broadcast ports
//           rob_head             oldest uncommitted ROB tag
//           store_buffer_full    downstream back-pressure
//           sq_*[NUM_SQ]         per-entry state and store image
//           cdb_sq_*             retiring store (zero when not valid)
// Revision: 1.0  initial release
// ============================================================================
module store_queue_mw
  import rv32i_types::*;
#(
  parameter int SQ_DEPTH    = 3,
  parameter int ROB_DEPTH   = 3,
  parameter int CDB_SIZE    = 4,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_flush,

  input  logic                 issue_valid       [ISSUE_WIDTH],
  input  logic [2:0]           issue_funct3      [ISSUE_WIDTH],
  input  logic [31:0]          issue_imm         [ISSUE_WIDTH],
  input  logic [ROB_DEPTH-1:0] issue_target_rob  [ISSUE_WIDTH],
  input  logic                 issue_rs1_ready   [ISSUE_WIDTH],
  input  logic [31:0]          issue_rs1_v       [ISSUE_WIDTH],
  input  logic [ROB_DEPTH-1:0] issue_rs1_rob     [ISSUE_WIDTH],
  input  logic                 issue_rs2_ready   [ISSUE_WIDTH],
  input  logic [31:0]          issue_rs2_v       [ISSUE_WIDTH],
  input  logic [ROB_DEPTH-1:0] issue_rs2_rob     [ISSUE_WIDTH],

  output logic                 sq_alloc_ready,
  output logic [SQ_DEPTH:0]    sq_free_count,
  output logic [SQ_DEPTH-1:0]  sq_alloc_ptr,

  input  logic                 cdb_valid         [CDB_SIZE],
  input  logic [ROB_DEPTH-1:0] cdb_rob           [CDB_SIZE],
  input  logic [31:0]          cdb_rd_v          [CDB_SIZE],

  input  logic [ROB_DEPTH-1:0] rob_head,
  input  logic                 store_buffer_full,

  output logic                 sq_valid          [2**SQ_DEPTH],
  output logic                 sq_addr_ready     [2**SQ_DEPTH],
  output logic                 sq_data_ready     [2**SQ_DEPTH],
  output logic [31:0]          sq_addr           [2**SQ_DEPTH],
  output logic [31:0]          sq_wdata          [2**SQ_DEPTH],
  output logic [3:0]           sq_wmask          [2**SQ_DEPTH],

  output logic                 cdb_sq_valid,
  output logic [ROB_DEPTH-1:0] cdb_sq_rob,
  output logic [31:0]          cdb_sq_addr,
  output logic [3:0]           cdb_sq_wmask,
  output logic [31:0]          cdb_sq_wdata
);

  localparam int                c_NUM_SQ     = 2**SQ_DEPTH;
  localparam logic [SQ_DEPTH:0] c_NUM_SQ_W   = (SQ_DEPTH+1)'(c_NUM_SQ);
  localparam logic [SQ_DEPTH:0] c_ISSUE_W    = (SQ_DEPTH+1)'(ISSUE_WIDTH);
  localparam logic [SQ_DEPTH:0] c_ONE        = (SQ_DEPTH+1)'(1);

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  logic                 r_valid    [c_NUM_SQ];
  logic [2:0]           r_funct3   [c_NUM_SQ];
  logic [31:0]          r_imm      [c_NUM_SQ];
  logic [ROB_DEPTH-1:0] r_rob      [c_NUM_SQ];
  logic                 r_rs1_rdy  [c_NUM_SQ];
  logic [31:0]          r_rs1_v    [c_NUM_SQ];
  logic [ROB_DEPTH-1:0] r_rs1_rob  [c_NUM_SQ];
  logic                 r_rs2_rdy  [c_NUM_SQ];
  logic [31:0]          r_rs2_v    [c_NUM_SQ];
  logic [ROB_DEPTH-1:0] r_rs2_rob  [c_NUM_SQ];

  logic                 w_nxt_valid   [c_NUM_SQ];
  logic [2:0]           w_nxt_funct3  [c_NUM_SQ];
  logic [31:0]          w_nxt_imm     [c_NUM_SQ];
  logic [ROB_DEPTH-1:0] w_nxt_rob     [c_NUM_SQ];
  logic                 w_nxt_rs1_rdy [c_NUM_SQ];
  logic [31:0]          w_nxt_rs1_v   [c_NUM_SQ];
  logic [ROB_DEPTH-1:0] w_nxt_rs1_rob [c_NUM_SQ];
  logic                 w_nxt_rs2_rdy [c_NUM_SQ];
  logic [31:0]          w_nxt_rs2_v   [c_NUM_SQ];
  logic [ROB_DEPTH-1:0] w_nxt_rs2_rob [c_NUM_SQ];

  logic [SQ_DEPTH-1:0]  r_alloc_ptr;
  logic [SQ_DEPTH-1:0]  r_ret_ptr;
  logic [SQ_DEPTH:0]    r_occ;

  logic [31:0]          w_addr       [c_NUM_SQ];
  logic                 w_data_ready [c_NUM_SQ];

  // --------------------------------------------------------------------------
  // Occupancy / allocation readiness
  // --------------------------------------------------------------------------
  logic [SQ_DEPTH:0]    w_free;
  logic                 w_alloc_go;

  assign w_free         = c_NUM_SQ_W - r_occ;
  assign w_alloc_go     = (w_free >= c_ISSUE_W);
  assign sq_free_count  = w_free;
  assign sq_alloc_ready = w_alloc_go;
  assign sq_alloc_ptr   = r_alloc_ptr;

  // --------------------------------------------------------------------------
  // Lane compaction and issue-time operand bypass
  // --------------------------------------------------------------------------
  logic [SQ_DEPTH-1:0]  w_lane_slot    [ISSUE_WIDTH];
  logic [SQ_DEPTH:0]    w_lane_cnt;
  logic                 w_lane_rs1_rdy [ISSUE_WIDTH];
  logic [31:0]          w_lane_rs1_v   [ISSUE_WIDTH];
  logic                 w_lane_rs2_rdy [ISSUE_WIDTH];
  logic [31:0]          w_lane_rs2_v   [ISSUE_WIDTH];

  always_comb begin : p_lane
    w_lane_cnt = '0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      // Each valid lane takes the next slot after the valid lanes before it
      w_lane_slot[l] = r_alloc_ptr + w_lane_cnt[SQ_DEPTH-1:0];
      if (issue_valid[l]) begin
        w_lane_cnt = w_lane_cnt + c_ONE;
      end

      w_lane_rs1_rdy[l] = issue_rs1_ready[l];
      w_lane_rs1_v[l]   = issue_rs1_v[l];
      w_lane_rs2_rdy[l] = issue_rs2_ready[l];
      w_lane_rs2_v[l]   = issue_rs2_v[l];
      // Walk ports high to low so the lowest-index match is the one kept
      for (int c = CDB_SIZE - 1; c >= 0; c--) begin
        if (!issue_rs1_ready[l] && cdb_valid[c] && (cdb_rob[c] == issue_rs1_rob[l])) begin
          w_lane_rs1_rdy[l] = 1'b1;
          w_lane_rs1_v[l]   = cdb_rd_v[c];
        end
        if (!issue_rs2_ready[l] && cdb_valid[c] && (cdb_rob[c] == issue_rs2_rob[l])) begin
          w_lane_rs2_rdy[l] = 1'b1;
          w_lane_rs2_v[l]   = cdb_rd_v[c];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Retire decision (head entry only)
  // --------------------------------------------------------------------------
  logic        w_retire;
  logic [3:0]  w_ret_wmask;
  logic [31:0] w_ret_wdata;

  // A flushing cycle never reports a retire since the entry is squashed
  assign w_retire = !rst && !move_flush && w_data_ready[r_ret_ptr] &&
                    (r_rob[r_ret_ptr] == rob_head) && !store_buffer_full;

  store_align u_retire_align (
    .addr_lo (w_addr[r_ret_ptr][1:0]),
    .funct3  (r_funct3[r_ret_ptr]),
    .rs2     (r_rs2_v[r_ret_ptr]),
    .wmask   (w_ret_wmask),
    .wdata   (w_ret_wdata)
  );

  assign cdb_sq_valid = w_retire;
  assign cdb_sq_rob   = w_retire ? r_rob[r_ret_ptr]  : '0;
  assign cdb_sq_addr  = w_retire ? w_addr[r_ret_ptr] : 32'h0;
  assign cdb_sq_wmask = w_retire ? w_ret_wmask       : 4'h0;
  assign cdb_sq_wdata = w_retire ? w_ret_wdata       : 32'h0;

  // --------------------------------------------------------------------------
  // Per-entry next state: CDB snoop, retire clear, allocation write.
  // Allocation only targets free slots and snoop only touches valid ones,
  // so the three updates never collide on the same entry.
  // --------------------------------------------------------------------------
  always_comb begin : p_entry_next
    for (int i = 0; i < c_NUM_SQ; i++) begin
      w_nxt_valid[i]   = r_valid[i];
      w_nxt_funct3[i]  = r_funct3[i];
      w_nxt_imm[i]     = r_imm[i];
      w_nxt_rob[i]     = r_rob[i];
      w_nxt_rs1_rdy[i] = r_rs1_rdy[i];
      w_nxt_rs1_v[i]   = r_rs1_v[i];
      w_nxt_rs1_rob[i] = r_rs1_rob[i];
      w_nxt_rs2_rdy[i] = r_rs2_rdy[i];
      w_nxt_rs2_v[i]   = r_rs2_v[i];
      w_nxt_rs2_rob[i] = r_rs2_rob[i];

      for (int c = CDB_SIZE - 1; c >= 0; c--) begin
        if (r_valid[i] && !r_rs1_rdy[i] && cdb_valid[c] && (cdb_rob[c] == r_rs1_rob[i])) begin
          w_nxt_rs1_rdy[i] = 1'b1;
          w_nxt_rs1_v[i]   = cdb_rd_v[c];
        end
        if (r_valid[i] && !r_rs2_rdy[i] && cdb_valid[c] && (cdb_rob[c] == r_rs2_rob[i])) begin
          w_nxt_rs2_rdy[i] = 1'b1;
          w_nxt_rs2_v[i]   = cdb_rd_v[c];
        end
      end

      if (w_retire && (r_ret_ptr == SQ_DEPTH'(i))) begin
        w_nxt_valid[i]   = 1'b0;
        w_nxt_funct3[i]  = 3'b000;
        w_nxt_imm[i]     = 32'h0;
        w_nxt_rob[i]     = '0;
        w_nxt_rs1_rdy[i] = 1'b0;
        w_nxt_rs1_v[i]   = 32'h0;
        w_nxt_rs1_rob[i] = '0;
        w_nxt_rs2_rdy[i] = 1'b0;
        w_nxt_rs2_v[i]   = 32'h0;
        w_nxt_rs2_rob[i] = '0;
      end

      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (w_alloc_go && issue_valid[l] && (w_lane_slot[l] == SQ_DEPTH'(i))) begin
          w_nxt_valid[i]   = 1'b1;
          w_nxt_funct3[i]  = issue_funct3[l];
          w_nxt_imm[i]     = issue_imm[l];
          w_nxt_rob[i]     = issue_target_rob[l];
          w_nxt_rs1_rdy[i] = w_lane_rs1_rdy[l];
          w_nxt_rs1_v[i]   = w_lane_rs1_v[l];
          w_nxt_rs1_rob[i] = issue_rs1_rob[l];
          w_nxt_rs2_rdy[i] = w_lane_rs2_rdy[l];
          w_nxt_rs2_v[i]   = w_lane_rs2_v[l];
          w_nxt_rs2_rob[i] = issue_rs2_rob[l];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [SQ_DEPTH:0] w_alloc_cnt;
  logic [SQ_DEPTH:0] w_occ_nxt;

  assign w_alloc_cnt = w_alloc_go ? w_lane_cnt : '0;
  // Retire frees the head while allocation fills from the old free count,
  // so the freed slot only becomes usable on the following cycle
  assign w_occ_nxt   = r_occ + w_alloc_cnt - (SQ_DEPTH+1)'(w_retire);

  always_ff @(posedge clk) begin
    if (rst || move_flush) begin
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
      r_occ       <= '0;
      for (int i = 0; i < c_NUM_SQ; i++) begin
        r_valid[i]   <= 1'b0;
        r_funct3[i]  <= 3'b000;
        r_imm[i]     <= 32'h0;
        r_rob[i]     <= '0;
        r_rs1_rdy[i] <= 1'b0;
        r_rs1_v[i]   <= 32'h0;
        r_rs1_rob[i] <= '0;
        r_rs2_rdy[i] <= 1'b0;
        r_rs2_v[i]   <= 32'h0;
        r_rs2_rob[i] <= '0;
      end
    end else begin
      r_alloc_ptr <= r_alloc_ptr + w_alloc_cnt[SQ_DEPTH-1:0];
      r_ret_ptr   <= r_ret_ptr + SQ_DEPTH'(w_retire);
      r_occ       <= w_occ_nxt;
      for (int i = 0; i < c_NUM_SQ; i++) begin
        r_valid[i]   <= w_nxt_valid[i];
        r_funct3[i]  <= w_nxt_funct3[i];
        r_imm[i]     <= w_nxt_imm[i];
        r_rob[i]     <= w_nxt_rob[i];
        r_rs1_rdy[i] <= w_nxt_rs1_rdy[i];
        r_rs1_v[i]   <= w_nxt_rs1_v[i];
        r_rs1_rob[i] <= w_nxt_rs1_rob[i];
        r_rs2_rdy[i] <= w_nxt_rs2_rdy[i];
        r_rs2_v[i]   <= w_nxt_rs2_v[i];
        r_rs2_rob[i] <= w_nxt_rs2_rob[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-entry outputs and store image
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < c_NUM_SQ; g++) begin : g_entry
    assign w_addr[g]        = r_rs1_v[g] + r_imm[g];
    assign w_data_ready[g]  = r_valid[g] & r_rs1_rdy[g] & r_rs2_rdy[g];
    assign sq_valid[g]      = r_valid[g];
    assign sq_addr_ready[g] = r_valid[g] & r_rs1_rdy[g];
    assign sq_data_ready[g] = w_data_ready[g];
    assign sq_addr[g]       = w_addr[g];

    store_align u_align (
      .addr_lo (w_addr[g][1:0]),
      .funct3  (r_funct3[g]),
      .rs2     (r_rs2_v[g]),
      .wmask   (sq_wmask[g]),
      .wdata   (sq_wdata[g])
    );
  end

endmodule : store_queue_mw
`default_nettype wire

// File: tb/tb_store_queue_mw.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_queue_mw
// Purpose : Directed testbench for store_queue_mw. Stimulus pushes expected
//           retiring stores into a queue; a monitor on the opposite clock
//           edge pops and compares whenever cdb_sq_valid is presented.
//           State checks are made one time unit after the active edge.
// Revision: 1.0  initial release
// ============================================================================
module tb_store_queue_mw;

  localparam int NSQ = 8;
  localparam int IW  = 2;
  localparam int NC  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_flush;
  logic        issue_valid      [IW];
  logic [2:0]  issue_funct3     [IW];
  logic [31:0] issue_imm        [IW];
  logic [2:0]  issue_target_rob [IW];
  logic        issue_rs1_ready  [IW];
  logic [31:0] issue_rs1_v      [IW];
  logic [2:0]  issue_rs1_rob    [IW];
  logic        issue_rs2_ready  [IW];
  logic [31:0] issue_rs2_v      [IW];
  logic [2:0]  issue_rs2_rob    [IW];
  logic        sq_alloc_ready;
  logic [3:0]  sq_free_count;
  logic [2:0]  sq_alloc_ptr;
  logic        cdb_valid [NC];
  logic [2:0]  cdb_rob   [NC];
  logic [31:0] cdb_rd_v  [NC];
  logic [2:0]  rob_head;
  logic        store_buffer_full;
  logic        sq_valid      [NSQ];
  logic        sq_addr_ready [NSQ];
  logic        sq_data_ready [NSQ];
  logic [31:0] sq_addr       [NSQ];
  logic [31:0] sq_wdata      [NSQ];
  logic [3:0]  sq_wmask      [NSQ];
  logic        cdb_sq_valid;
  logic [2:0]  cdb_sq_rob;
  logic [31:0] cdb_sq_addr;
  logic [3:0]  cdb_sq_wmask;
  logic [31:0] cdb_sq_wdata;

  store_queue_mw #(
    .SQ_DEPTH(3), .ROB_DEPTH(3), .CDB_SIZE(NC), .ISSUE_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .move_flush(move_flush),
    .issue_valid(issue_valid), .issue_funct3(issue_funct3), .issue_imm(issue_imm),
    .issue_target_rob(issue_target_rob),
    .issue_rs1_ready(issue_rs1_ready), .issue_rs1_v(issue_rs1_v), .issue_rs1_rob(issue_rs1_rob),
    .issue_rs2_ready(issue_rs2_ready), .issue_rs2_v(issue_rs2_v), .issue_rs2_rob(issue_rs2_rob),
    .sq_alloc_ready(sq_alloc_ready), .sq_free_count(sq_free_count), .sq_alloc_ptr(sq_alloc_ptr),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
    .rob_head(rob_head), .store_buffer_full(store_buffer_full),
    .sq_valid(sq_valid), .sq_addr_ready(sq_addr_ready), .sq_data_ready(sq_data_ready),
    .sq_addr(sq_addr), .sq_wdata(sq_wdata), .sq_wmask(sq_wmask),
    .cdb_sq_valid(cdb_sq_valid), .cdb_sq_rob(cdb_sq_rob), .cdb_sq_addr(cdb_sq_addr),
    .cdb_sq_wmask(cdb_sq_wmask), .cdb_sq_wdata(cdb_sq_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rob;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } ret_t;

  ret_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_issue();
    for (int l = 0; l < IW; l++) begin
      issue_valid[l] = 1'b0;      issue_funct3[l] = 3'd0;  issue_imm[l] = 32'h0;
      issue_target_rob[l] = 3'd0; issue_rs1_ready[l] = 1'b0; issue_rs1_v[l] = 32'h0;
      issue_rs1_rob[l] = 3'd0;    issue_rs2_ready[l] = 1'b0; issue_rs2_v[l] = 32'h0;
      issue_rs2_rob[l] = 3'd0;
    end
  endtask

  task automatic clear_cdb();
    for (int c = 0; c < NC; c++) begin
      cdb_valid[c] = 1'b0; cdb_rob[c] = 3'd0; cdb_rd_v[c] = 32'h0;
    end
  endtask

  task automatic set_cdb(input int p, input logic [2:0] tag, input logic [31:0] v);
    cdb_valid[p] = 1'b1; cdb_rob[p] = tag; cdb_rd_v[p] = v;
  endtask

  task automatic set_lane(input int l, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [2:0] tag,
                          input logic r1rdy, input logic [31:0] r1v, input logic [2:0] r1rob,
                          input logic r2rdy, input logic [31:0] r2v, input logic [2:0] r2rob);
    issue_valid[l] = 1'b1;       issue_funct3[l] = f3;       issue_imm[l] = imm;
    issue_target_rob[l] = tag;   issue_rs1_ready[l] = r1rdy; issue_rs1_v[l] = r1v;
    issue_rs1_rob[l] = r1rob;    issue_rs2_ready[l] = r2rdy; issue_rs2_v[l] = r2v;
    issue_rs2_rob[l] = r2rob;
  endtask

  task automatic push_ret(input logic [2:0] rob, input logic [31:0] addr,
                          input logic [3:0] wmask, input logic [31:0] wdata);
    ret_t e;
    e.rob = rob; e.addr = addr; e.wmask = wmask; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  // Retire monitor: every presented retire must match the oldest expectation
  always @(negedge clk) begin
    ret_t e;
    if (!rst && !move_flush && cdb_sq_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL retire_unexpected: got rob %0d addr 0x%0h, required no retire",
                 cdb_sq_rob, cdb_sq_addr);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (cdb_sq_rob !== e.rob || cdb_sq_addr !== e.addr ||
            cdb_sq_wmask !== e.wmask || cdb_sq_wdata !== e.wdata) begin
          n_errors++;
          $display("FAIL retire_image: got rob %0d addr 0x%0h mask 0x%0h data 0x%0h, required rob %0d addr 0x%0h mask 0x%0h data 0x%0h",
                   cdb_sq_rob, cdb_sq_addr, cdb_sq_wmask, cdb_sq_wdata,
                   e.rob, e.addr, e.wmask, e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; move_flush = 1'b0; rob_head = 3'd7; store_buffer_full = 1'b0;
    clear_issue(); clear_cdb();
    tick(); tick();
    rst = 1'b0;

    // ---------------- reset state
    chk("rst_free", sq_free_count, 8);
    chk("rst_alloc_ready", sq_alloc_ready, 1);
    chk("rst_alloc_ptr", sq_alloc_ptr, 0);
    for (int i = 0; i < NSQ; i++) begin
      chk($sformatf("rst_valid%0d", i), sq_valid[i], 0);
      chk($sformatf("rst_ardy%0d", i), sq_addr_ready[i], 0);
      chk($sformatf("rst_drdy%0d", i), sq_data_ready[i], 0);
      chk($sformatf("rst_addr%0d", i), sq_addr[i], 0);
      chk($sformatf("rst_wdata%0d", i), sq_wdata[i], 0);
      chk($sformatf("rst_wmask%0d", i), sq_wmask[i], 4'b0001);
    end
    chk("rst_cdb_valid", cdb_sq_valid, 0);
    chk("rst_cdb_addr", cdb_sq_addr, 0);

    // ---------------- two-lane sw + sb, all ready
    set_lane(0, 3'd2, 32'd4, 3'd0, 1, 32'h100, 0, 1, 32'hDEADBEEF, 3'd6);
    set_lane(1, 3'd0, 32'd0, 3'd1, 1, 32'h203, 0, 1, 32'h000000AB, 0);
    tick(); clear_issue();
    chk("two_lane_free", sq_free_count, 6);
    chk("two_lane_ptr", sq_alloc_ptr, 2);
    chk("e0_valid", sq_valid[0], 1);
    chk("e0_addr", sq_addr[0], 32'h104);
    chk("e0_wmask", sq_wmask[0], 4'b1111);
    chk("e0_wdata", sq_wdata[0], 32'hDEADBEEF);
    chk("e0_drdy", sq_data_ready[0], 1);
    chk("e1_addr", sq_addr[1], 32'h203);
    chk("e1_wmask", sq_wmask[1], 4'b1000);
    chk("e1_wdata", sq_wdata[1], 32'hAB000000);

    // ---------------- same-cycle CDB bypass, lowest port wins
    set_lane(0, 3'd2, 32'd0, 3'd2, 1, 32'h300, 0, 0, 32'h0, 3'd5);
    set_cdb(0, 3'd4, 32'hFFFF); set_cdb(2, 3'd5, 32'h1234); set_cdb(3, 3'd5, 32'h9999);
    tick(); clear_issue(); clear_cdb();
    chk("bypass_drdy", sq_data_ready[2], 1);
    chk("bypass_wdata", sq_wdata[2], 32'h1234);
    chk("bypass_free", sq_free_count, 5);

    // ---------------- sh with pending rs2, captured later from CDB
    set_lane(0, 3'd1, 32'd0, 3'd3, 1, 32'h202, 0, 0, 32'h0, 3'd6);
    tick(); clear_issue();
    chk("sh_ardy", sq_addr_ready[3], 1);
    chk("sh_drdy_wait", sq_data_ready[3], 0);
    chk("sh_addr", sq_addr[3], 32'h202);

    // lane 1 only (compaction) with funct3=3, while CDB wakes entry 3
    set_lane(1, 3'd3, 32'd0, 3'd4, 1, 32'h400, 0, 1, 32'h12345678, 0);
    set_cdb(1, 3'd6, 32'hBEEF); set_cdb(3, 3'd6, 32'h5555);
    tick(); clear_issue(); clear_cdb();
    chk("sh_drdy", sq_data_ready[3], 1);
    chk("sh_wmask", sq_wmask[3], 4'b1100);
    chk("sh_wdata", sq_wdata[3], 32'hBEEF0000);
    chk("ready_operand_kept", sq_wdata[0], 32'hDEADBEEF);
    chk("f3_valid", sq_valid[4], 1);
    chk("f3_wmask", sq_wmask[4], 4'b0000);
    chk("f3_wdata", sq_wdata[4], 32'h0);
    chk("compact_ptr", sq_alloc_ptr, 5);

    // ---------------- fill until not ready
    set_lane(0, 3'd2, 32'd0, 3'd5, 1, 32'h500, 0, 1, 32'h5A5A5A5A, 0);
    tick(); clear_issue();
    chk("fill_free2", sq_free_count, 2);
    chk("fill_ready2", sq_alloc_ready, 1);
    set_lane(0, 3'd2, 32'd0, 3'd6, 1, 32'h600, 0, 1, 32'h66, 0);
    tick(); clear_issue();
    chk("fill_free1", sq_free_count, 1);
    chk("fill_not_ready", sq_alloc_ready, 0);
    set_lane(0, 3'd2, 32'd0, 3'd7, 1, 32'h700, 0, 1, 32'h77, 0);
    set_lane(1, 3'd2, 32'd0, 3'd7, 1, 32'h800, 0, 1, 32'h88, 0);
    tick(); clear_issue();
    chk("ignored_free", sq_free_count, 1);
    chk("ignored_ptr", sq_alloc_ptr, 7);
    chk("ignored_valid7", sq_valid[7], 0);

    // ---------------- retire holds
    rob_head = 3'd0; store_buffer_full = 1'b1;
    @(negedge clk);
    chk("hold_sbfull_valid", cdb_sq_valid, 0);
    chk("hold_sbfull_addr", cdb_sq_addr, 0);
    tick();
    rob_head = 3'd7; store_buffer_full = 1'b0;
    @(negedge clk);
    chk("hold_rob_valid", cdb_sq_valid, 0);
    chk("hold_rob_wdata", cdb_sq_wdata, 0);
    tick();

    // ---------------- release: retire only, issue ignored (not ready)
    rob_head = 3'd0;
    set_lane(0, 3'd2, 32'd0, 3'd3, 1, 32'h900, 0, 1, 32'h99, 0);
    set_lane(1, 3'd2, 32'd0, 3'd3, 1, 32'h904, 0, 1, 32'h99, 0);
    push_ret(3'd0, 32'h104, 4'b1111, 32'hDEADBEEF);
    tick(); clear_issue(); rob_head = 3'd3;
    chk("ret0_free", sq_free_count, 2);
    chk("ret0_ptr", sq_alloc_ptr, 7);
    chk("ret0_valid0", sq_valid[0], 0);
    chk("ret0_valid7", sq_valid[7], 0);
    chk("ret0_cleared_addr", sq_addr[0], 0);
    chk("ret0_cleared_wmask", sq_wmask[0], 4'b0001);

    // ---------------- wrap: entries 7 and 0
    set_lane(0, 3'd0, 32'd1, 3'd7, 1, 32'h10, 0, 1, 32'h77, 0);
    set_lane(1, 3'd2, 32'hFFFFFFFC, 3'd0, 1, 32'h40, 0, 1, 32'hCAFEF00D, 0);
    tick(); clear_issue();
    chk("wrap_valid7", sq_valid[7], 1);
    chk("wrap_wmask7", sq_wmask[7], 4'b0010);
    chk("wrap_wdata7", sq_wdata[7], 32'h00007700);
    chk("wrap_valid0", sq_valid[0], 1);
    chk("wrap_addr0", sq_addr[0], 32'h3C);
    chk("wrap_ptr", sq_alloc_ptr, 1);
    chk("wrap_free", sq_free_count, 0);
    chk("wrap_not_ready", sq_alloc_ready, 0);

    // ---------------- in-order retires
    rob_head = 3'd1;
    push_ret(3'd1, 32'h203, 4'b1000, 32'hAB000000);
    tick();
    chk("ret1_free", sq_free_count, 1);
    rob_head = 3'd2;
    push_ret(3'd2, 32'h300, 4'b1111, 32'h1234);
    tick();
    chk("ret2_free", sq_free_count, 2);

    // ---------------- simultaneous retire + 2-lane allocation
    rob_head = 3'd3;
    push_ret(3'd3, 32'h202, 4'b1100, 32'hBEEF0000);
    set_lane(0, 3'd2, 32'd0, 3'd1, 1, 32'h700, 0, 1, 32'h11, 0);
    set_lane(1, 3'd2, 32'd0, 3'd2, 1, 32'h704, 0, 1, 32'h22, 0);
    tick(); clear_issue();
    chk("simul_free", sq_free_count, 1);
    chk("simul_ptr", sq_alloc_ptr, 3);
    chk("simul_valid1", sq_valid[1], 1);
    chk("simul_addr2", sq_addr[2], 32'h704);
    chk("simul_valid3", sq_valid[3], 0);

    // ---------------- flush with issue and retire active
    rob_head = 3'd4; move_flush = 1'b1;
    set_lane(0, 3'd2, 32'd0, 3'd5, 1, 32'hA00, 0, 1, 32'hAA, 0);
    set_lane(1, 3'd2, 32'd0, 3'd6, 1, 32'hB00, 0, 1, 32'hBB, 0);
    tick(); clear_issue(); move_flush = 1'b0;
    chk("flush_free", sq_free_count, 8);
    chk("flush_ready", sq_alloc_ready, 1);
    chk("flush_ptr", sq_alloc_ptr, 0);
    for (int i = 0; i < NSQ; i++) chk($sformatf("flush_valid%0d", i), sq_valid[i], 0);
    chk("flush_cdb_valid", cdb_sq_valid, 0);

    // ---------------- allocate and retire after flush
    rob_head = 3'd2;
    set_lane(0, 3'd2, 32'd8, 3'd2, 1, 32'h500, 0, 1, 32'h55AA55AA, 0);
    tick(); clear_issue();
    chk("post_flush_free", sq_free_count, 7);
    push_ret(3'd2, 32'h508, 4'b1111, 32'h55AA55AA);
    tick();
    chk("post_flush_ret_free", sq_free_count, 8);
    chk("post_flush_ret_valid", sq_valid[0], 0);

    tick(); tick(); tick();
    chk("retire_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_store_queue_mw
`default_nettype wire
